// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Keeps one request outstanding to
//               instruction memory at a time, accepts redirects from execute,
//               drops responses made stale by a redirect, and presents each
//               fetched word to decode with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1   clock, rising edge
//   rst              in   1   asynchronous reset, active low
//   redirect_valid   in   1   redirect pulse from execute
//   redirect_pc      in  64   redirect target
//   inst_req_valid   out  1   fetch request valid
//   inst_req_addr    out 64   fetch byte address
//   inst_req_ready   in   1   memory accepts the request
//   inst_resp_valid  in   1   fetch data valid (one pulse per accepted request)
//   inst_resp_data   in  32   fetched instruction word
//   if_valid         out  1   instruction presented to decode
//   if_pc            out 64   PC of the presented instruction
//   if_inst          out 32   presented instruction
//   id_ready         in   1   decode consumes the presented instruction
//   if_misalign      out  1   presented beat is a misaligned-target fault
// ----------------------------------------------------------------------------
// Configuration
//   IF_MISALIGN_CHECK_EN  defined   : a redirect whose target has bits [1:0]
//                                     non-zero parks the stage in HALT and
//                                     presents a fault beat (if_inst = NOP).
//                         undefined : redirect targets are forced to word
//                                     alignment; HALT is unreachable and
//                                     if_misalign stays 0.
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_req_valid,
  output logic [63:0] inst_req_addr,
  input  logic        inst_req_ready,
  input  logic        inst_resp_valid,
  input  logic [31:0] inst_resp_data,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready,
  output logic        if_misalign
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    KILL = 3'd4,
    HALT = 3'd5
  } state_t;

  localparam logic [31:0] FAULT_INST = 32'h0000_0013;

  state_t      state;
  state_t      state_nx;
  logic [63:0] pc;
  logic [63:0] pc_nx;
  logic        latch_resp;   // capture the response into if_pc/if_inst
  logic [63:0] tgt;          // redirect target as it is loaded into pc
  logic        tgt_misaligned;
  logic        halt_entry;
  logic        req_hs;

`ifdef IF_MISALIGN_CHECK_EN
  assign tgt            = redirect_pc;
  assign tgt_misaligned = |redirect_pc[1:0];
`else
  // Low bits are simply cleared; a misaligned target can never be fetched.
  assign tgt            = redirect_pc & ~64'h3;
  assign tgt_misaligned = 1'b0;
`endif

  assign halt_entry = redirect_valid && tgt_misaligned;
  assign req_hs     = (state == REQ) && inst_req_ready;

  // Next-state / next-pc decode. Outputs are registered from these values so
  // every output is a flop and reset clears them immediately.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    latch_resp = 1'b0;
    case (state)
      IDLE: begin
        state_nx = REQ;
        if (redirect_valid) pc_nx = tgt;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_nx = tgt;
          // An accepted request still owes a response, which KILL absorbs.
          state_nx = req_hs ? KILL : REQ;
        end else if (req_hs) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nx    = tgt;
          state_nx = inst_resp_valid ? REQ : KILL;
        end else if (inst_resp_valid) begin
          latch_resp = 1'b1;
          state_nx   = OUT;
        end
      end
      KILL: begin
        if (redirect_valid) pc_nx = tgt;
        // Once the orphaned response shows up nothing is outstanding.
        if (inst_resp_valid) state_nx = REQ;
      end
      OUT: begin
        if (redirect_valid) begin
          pc_nx    = tgt;
          state_nx = REQ;
        end else if (id_ready) begin
          pc_nx    = pc + 64'd4;
          state_nx = REQ;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_nx    = tgt;
          state_nx = REQ;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // A misaligned target overrides every other transition.
    if (halt_entry) state_nx = HALT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pc             <= PC_START;
      inst_req_valid <= 1'b0;
      inst_req_addr  <= '0;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_inst        <= '0;
      if_misalign    <= 1'b0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      inst_req_valid <= (state_nx == REQ);
      inst_req_addr  <= (state_nx == REQ) ? pc_nx : '0;
      if_valid       <= (state_nx == OUT) || (state_nx == HALT);
      if_misalign    <= (state_nx == HALT);
      if (latch_resp) begin
        if_pc   <= pc;
        if_inst <= inst_resp_data;
      end else if (halt_entry) begin
        if_pc   <= redirect_pc;
        if_inst <= FAULT_INST;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_req_valid;
  logic [63:0] inst_req_addr;
  logic        inst_req_ready = 1'b0;
  logic        inst_resp_valid = 1'b0;
  logic [31:0] inst_resp_data = '0;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b0;
  logic        if_misalign;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_req_valid  (inst_req_valid),
    .inst_req_addr   (inst_req_addr),
    .inst_req_ready  (inst_req_ready),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_data  (inst_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .id_ready        (id_ready),
    .if_misalign     (if_misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } out_t;

  logic [63:0] addr_q[$];
  out_t        out_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_zero(input string tag);
    chk({tag, "_req_valid"}, 64'(inst_req_valid), 64'd0);
    chk({tag, "_req_addr"},  inst_req_addr,       64'd0);
    chk({tag, "_if_valid"},  64'(if_valid),       64'd0);
    chk({tag, "_if_pc"},     if_pc,               64'd0);
    chk({tag, "_if_inst"},   64'(if_inst),        64'd0);
    chk({tag, "_misalign"},  64'(if_misalign),    64'd0);
  endtask

  // Wait (bounded) for a request and compare its address with the scoreboard.
  task automatic wait_req(input string tag);
    logic [63:0] e;
    for (int i = 0; i < 20; i++) begin
      if (inst_req_valid) break;
      @(negedge clk);
    end
    chk({tag, "_req_valid"}, 64'(inst_req_valid), 64'd1);
    e = (addr_q.size() != 0) ? addr_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk({tag, "_req_addr"}, inst_req_addr, e);
  endtask

  // Wait (bounded) for a presented beat and compare with the scoreboard.
  task automatic wait_out(input string tag);
    out_t e;
    for (int i = 0; i < 20; i++) begin
      if (if_valid) break;
      @(negedge clk);
    end
    chk({tag, "_if_valid"}, 64'(if_valid), 64'd1);
    e = (out_q.size() != 0) ? out_q.pop_front() : '1;
    chk({tag, "_if_pc"},    if_pc,             e.pc);
    chk({tag, "_if_inst"},  64'(if_inst),      64'(e.inst));
    chk({tag, "_misalign"}, 64'(if_misalign),  64'(e.mis));
  endtask

  // Called at the negedge where a request is about to be accepted:
  // response arrives the cycle after the handshake.
  task automatic deliver(input logic [31:0] data);
    @(negedge clk);
    inst_resp_valid = 1'b1;
    inst_resp_data  = data;
    @(negedge clk);
    inst_resp_valid = 1'b0;
  endtask

  task automatic consume();
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    reset_zero("reset");

    // ---------------- basic fetch from PC_START ----------------
    rst = 1'b1;
    inst_req_ready = 1'b1;
    addr_q.push_back(64'h8000_0000);
    wait_req("first");
    out_q.push_back('{pc: 64'h8000_0000, inst: 32'h0000_0513, mis: 1'b0});
    deliver(32'h0000_0513);
    wait_out("first");

    // decode stalls: beat held, no new request
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_if_valid", 64'(if_valid), 64'd1);
      chk("stall_if_pc",    if_pc,         64'h8000_0000);
      chk("stall_if_inst",  64'(if_inst),  64'h0000_0513);
      chk("stall_req",      64'(inst_req_valid), 64'd0);
    end
    consume();
    chk("after_out_if_valid", 64'(if_valid), 64'd0);
    addr_q.push_back(64'h8000_0004);
    wait_req("seq");

    // ---------------- redirect in WAIT, late response dropped ----------------
    @(negedge clk);                       // WAIT
    redirect(64'h8000_0100);              // -> KILL
    chk("kill_if_valid", 64'(if_valid), 64'd0);
    chk("kill_req",      64'(inst_req_valid), 64'd0);
    @(negedge clk);
    inst_resp_valid = 1'b1;
    inst_resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    inst_resp_valid = 1'b0;
    chk("kill_drop_if_valid", 64'(if_valid), 64'd0);
    addr_q.push_back(64'h8000_0100);
    wait_req("wait_redir");

    // ---------------- redirect coincident with response in WAIT ----------------
    @(negedge clk);                       // WAIT
    inst_resp_valid = 1'b1;
    inst_resp_data  = 32'hBAD0_BAD0;
    redirect(64'h8000_0200);
    inst_resp_valid = 1'b0;
    chk("resp_redir_if_valid", 64'(if_valid), 64'd0);
    addr_q.push_back(64'h8000_0200);
    wait_req("resp_redir");

    // ---------------- redirect coincident with request handshake ----------------
    redirect(64'h8000_0300);              // handshake + redirect -> KILL
    chk("hs_redir_req", 64'(inst_req_valid), 64'd0);
    inst_resp_valid = 1'b1;
    inst_resp_data  = 32'hBAD1_BAD1;
    @(negedge clk);
    inst_resp_valid = 1'b0;
    chk("hs_redir_if_valid", 64'(if_valid), 64'd0);
    addr_q.push_back(64'h8000_0300);
    wait_req("hs_redir");
    out_q.push_back('{pc: 64'h8000_0300, inst: 32'h0010_0093, mis: 1'b0});
    deliver(32'h0010_0093);
    wait_out("hs_redir");

    // ---------------- redirect beats id_ready in OUT ----------------
    id_ready = 1'b1;
    redirect(64'h8000_0500);
    id_ready = 1'b0;
    addr_q.push_back(64'h8000_0500);
    wait_req("out_redir");

    // ---------------- redirect in REQ without handshake ----------------
    inst_req_ready = 1'b0;
    redirect(64'h8000_0400);
    addr_q.push_back(64'h8000_0400);
    wait_req("req_redir");

    // ---------------- pc+4 wraps at the top of the address space ----------------
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    wait_req("top");
    inst_req_ready = 1'b1;
    out_q.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, inst: 32'h0000_0073, mis: 1'b0});
    deliver(32'h0000_0073);
    wait_out("top");
    consume();
    addr_q.push_back(64'h0);
    wait_req("wrap");

    // ---------------- asynchronous reset while WAIT ----------------
    @(negedge clk);                       // WAIT
    #2 rst = 1'b0;
    #1 reset_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    inst_resp_valid = 1'b1;               // stale response during IDLE
    inst_resp_data  = 32'hDEAD_0001;
    @(negedge clk);                       // REQ
    inst_req_ready  = 1'b0;
    inst_resp_data  = 32'hDEAD_0002;      // stale response during REQ
    @(negedge clk);
    inst_resp_valid = 1'b0;
    chk("stale_if_valid", 64'(if_valid), 64'd0);
    addr_q.push_back(64'h8000_0000);
    wait_req("post_rst");
    inst_req_ready = 1'b1;
    out_q.push_back('{pc: 64'h8000_0000, inst: 32'h00A0_0593, mis: 1'b0});
    deliver(32'h00A0_0593);
    wait_out("post_rst");
    consume();
    addr_q.push_back(64'h8000_0004);
    wait_req("post_rst_seq");
    inst_req_ready = 1'b0;

    // ---------------- misaligned redirect target ----------------
    redirect(64'h8000_0102);
`ifdef IF_MISALIGN_CHECK_EN
    out_q.push_back('{pc: 64'h8000_0102, inst: 32'h0000_0013, mis: 1'b1});
    wait_out("halt");
    chk("halt_req", 64'(inst_req_valid), 64'd0);
    id_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    id_ready = 1'b0;
    chk("halt_hold_if_valid", 64'(if_valid),       64'd1);
    chk("halt_hold_misalign", 64'(if_misalign),    64'd1);
    chk("halt_hold_req",      64'(inst_req_valid), 64'd0);
    redirect(64'h8000_0600);
    chk("halt_exit_misalign", 64'(if_misalign), 64'd0);
    addr_q.push_back(64'h8000_0600);
    wait_req("halt_exit");
`else
    addr_q.push_back(64'h8000_0100);
    wait_req("align");
    chk("align_misalign", 64'(if_misalign), 64'd0);
    chk("align_if_valid", 64'(if_valid),    64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_START, default 64'h0000_0000_8000_0000: PC fetched first after reset.
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-004 redirect_valid  input  1  branch/jump redirect from execute; one-cycle pulse.
REQ-005 redirect_pc  input  64  redirect target; sampled when redirect_valid=1.
REQ-006 inst_req_valid  output  1  fetch request valid.
REQ-007 inst_req_addr  output  64  fetch byte address.
REQ-008 inst_req_ready  input  1  memory accepts request; handshake = valid & ready.
REQ-009 inst_resp_valid  input  1  fetch data valid; one-cycle pulse per accepted request.
REQ-010 inst_resp_data  input  32  fetched instruction word.
REQ-011 if_valid  output  1  instruction presented to decode.
REQ-012 if_pc  output  64  PC of presented instruction.
REQ-013 if_inst  output  32  presented instruction.
REQ-014 id_ready  input  1  decode consumes presented instruction; handshake = if_valid & id_ready.
REQ-015 if_misalign  output  1  presented beat carries a misaligned-target fault (Configuration).

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, OUT, KILL, HALT; at most one memory request outstanding.
REQ-017 IDLE: no outputs asserted; unconditionally -> REQ next cycle.
REQ-018 REQ: inst_req_valid=1, inst_req_addr=pc; handshake without redirect -> WAIT; redirect without handshake -> pc<=redirect_pc, stay REQ; handshake and redirect same cycle -> pc<=redirect_pc, -> KILL.
REQ-019 WAIT: inst_resp_valid without redirect -> latch if_inst<=inst_resp_data, if_pc<=pc, -> OUT; redirect with inst_resp_valid -> drop data, pc<=redirect_pc, -> REQ; redirect alone -> pc<=redirect_pc, -> KILL.
REQ-020 KILL: inst_resp_valid -> drop data, -> REQ; redirect in KILL -> pc<=redirect_pc, stay KILL.
REQ-021 OUT: if_valid=1, if_pc/if_inst held stable until handshake or redirect; redirect (priority over id_ready) -> pc<=redirect_pc, -> REQ; id_ready alone -> pc<=pc+4, -> REQ.
REQ-022 if_valid SHALL be 1 only in OUT (and HALT per REQ-029); deasserted the cycle after leaving OUT.
REQ-023 pc+4 SHALL be 64-bit modulo (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-024 inst_resp_valid in IDLE, REQ, OUT, HALT SHALL be ignored.
REQ-025 Minimum latency: request handshake cycle N, response cycle N+1 -> if_valid at N+2.

Reset
REQ-026 While rst=0, immediately: state=IDLE, pc=PC_START, inst_req_valid=0, inst_req_addr=0, if_valid=0, if_pc=0, if_inst=0, if_misalign=0.
REQ-027 Reset mid-transaction SHALL abandon any outstanding request; a response arriving after reset release, before a new handshake, is ignored (state is IDLE/REQ).

Configuration
REQ-028 Macro IF_MISALIGN_CHECK_EN selects misaligned-target handling.
REQ-029 Defined: redirect_pc[1:0]!=0 -> no memory request; enter HALT presenting if_valid=1, if_misalign=1, if_pc=redirect_pc, if_inst=32'h0000_0013; id_ready does not leave HALT; only a redirect leaves HALT (normal REQ-018 target rules).
REQ-030 Undefined: pc<=redirect_pc with bits [1:0] forced to 0; HALT unreachable; if_misalign tied 0.

Verification
REQ-031 Reset release, req_ready=1, resp 1 cycle after accept with 32'h0000_0513 -> inst_req_addr=0x8000_0000, if_valid with if_pc=0x8000_0000, if_inst=0x0000_0513; after id_ready next inst_req_addr=0x8000_0004.
REQ-032 id_ready=0 for 5 cycles in OUT -> if_valid/if_pc/if_inst stable, inst_req_valid=0 throughout.
REQ-033 Redirect to 0x8000_0100 in WAIT, resp 2 cycles later -> response dropped, no if_valid for old PC, next inst_req_addr=0x8000_0100.
REQ-034 Redirect coincident with inst_resp_valid in WAIT, and coincident with request handshake in REQ -> data dropped, next request at redirect_pc.
REQ-035 rst=0 asserted in WAIT -> all outputs 0 same cycle; after release first request at 0x8000_0000, stale response ignored.
REQ-036 Redirect to 0x8000_0102 -> with IF_MISALIGN_CHECK_EN: if_valid=1, if_misalign=1, if_pc=0x8000_0102, if_inst=0x13, no request until next redirect; without: inst_req_addr=0x8000_0100.
